// File: rtl/uart_ram_fifo_ctrl.sv
// uart_ram_fifo_ctrl
// Byte FIFO between a UART receiver and a UART transmitter, built on an
// external 256x8 single-port RAM with a registered read port. RX writes
// always win the RAM port; reads are retried once the port is free. The
// byte being offered to the transmitter is held in a separate register,
// so the total buffering is 256 bytes in RAM plus one byte in tx_data.

module uart_ram_fifo_ctrl #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [8:0]        count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    // RD: waiting to launch a RAM read. LOAD: RAM data_out is valid this
    // cycle. HOLD: byte is offered to the transmitter until accepted.
    typedef enum logic [1:0] {
        ST_RD   = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_wr_ptr;
    logic [7:0]         r_rd_ptr;
    logic [8:0]         r_count;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_valid;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_accept;
    logic               w_drop;
    logic               w_rd_commit;
    logic               w_tx_handshake;

    assign w_full  = (r_count == 9'(DEPTH));
    assign w_empty = (r_count == 9'd0);

    // Writes are gated by reset so nothing reaches the RAM while held in reset.
    assign w_wr_accept    = rst_n && rx_valid && !w_full;
    assign w_drop         = rx_valid && w_full;
    // A read only launches when the RAM port is not taken by a write.
    assign w_rd_commit    = (r_state == ST_RD) && !w_empty && !w_wr_accept;
    assign w_tx_handshake = r_tx_valid && tx_ready;

    assign ram_we   = w_wr_accept;
    assign ram_addr = w_wr_accept ? r_wr_ptr : r_rd_ptr;
    assign ram_din  = rx_data;

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: RD -> LOAD on a committed read, LOAD -> HOLD always,
    // HOLD -> RD once the transmitter takes the byte.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RD: begin
                if (w_rd_commit) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_tx_handshake) begin
                    w_state_next = ST_RD;
                end
            end
            default: begin
                w_state_next = ST_RD;
            end
        endcase
    end

    // Pointers, occupancy and sticky overflow. Write and read commit are
    // mutually exclusive, so count only ever moves by one in either direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= 8'd0;
            r_rd_ptr   <= 8'd0;
            r_count    <= 9'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 8'd1;
                r_count  <= r_count + 9'd1;
            end else if (w_rd_commit) begin
                r_rd_ptr <= r_rd_ptr + 8'd1;
                r_count  <= r_count - 9'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transmit holding register: capture RAM output in LOAD, release on handshake.
    // The RAM leaves data_out alone on write cycles, so a write during LOAD is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_tx_data  <= ram_dout;
            r_tx_valid <= 1'b1;
        end else if ((r_state == ST_HOLD) && w_tx_handshake) begin
            r_tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_ram_fifo_ctrl.sv
// Directed testbench for uart_ram_fifo_ctrl with a behavioural 256x8 RAM
// (registered read, data_out untouched on write cycles). Inputs are driven
// on the falling edge; outputs are checked 1 time unit later.

module tb_uart_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [7:0] ram_dout = 8'h00;
    logic [8:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:255];
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_ram_fifo_ctrl #(
        .DEPTH  (256),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    // Behavioural single-port RAM: write or registered read, never both.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout <= mem[ram_addr];
    end

    // Record every byte the transmitter accepts (handshake at the next rising edge).
    always begin
        @(negedge clk);
        #2;
        if (rst_n && tx_valid && tx_ready) obs_q.push_back(tx_data);
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_obs(input string tag);
        check_val({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_val($sformatf("%s_%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        tx_ready = rdy;
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;

        // Reset held 3 cycles with rx_valid asserted: no RAM writes.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hC3, 1'b0);
            check_val("rst_we", ram_we, 1'b0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        #1;
        check_val("rst_tx_valid", tx_valid, 1'b0);
        check_val("rst_count", count, 9'd0);
        check_val("rst_empty", empty, 1'b1);
        check_val("rst_full", full, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_tx_data", tx_data, 8'h00);

        // Single byte latency.
        obs_q.delete();
        step(1'b1, 8'hA5, 1'b1);
        check_val("sb_we_w", ram_we, 1'b1);
        check_val("sb_addr_w", ram_addr, 8'h00);
        check_val("sb_txv_w", tx_valid, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_val("sb_we_r", ram_we, 1'b0);
        check_val("sb_addr_r", ram_addr, 8'h00);
        check_val("sb_count_r", count, 9'd1);
        step(1'b0, 8'h00, 1'b1);
        check_val("sb_txv_load", tx_valid, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_val("sb_txv_w3", tx_valid, 1'b1);
        check_val("sb_txd_w3", tx_data, 8'hA5);
        check_val("sb_count_w3", count, 9'd0);
        idle(2, 1'b1);
        check_val("sb_txv_done", tx_valid, 1'b0);
        check_val("sb_empty", empty, 1'b1);
        exp_q = '{8'hA5};
        check_obs("sb_out");

        // Burst of writes collides with the read; read deferred until burst ends.
        pulse_reset();
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(i + 1), 1'b1);
            check_val("bu_we", ram_we, 1'b1);
            check_val("bu_waddr", ram_addr, 8'(i));
        end
        step(1'b0, 8'h00, 1'b1);
        check_val("bu_rd_we", ram_we, 1'b0);
        check_val("bu_raddr0", ram_addr, 8'h00);
        check_val("bu_count", count, 9'd4);
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 8'h00, 1'b1);
            if ((k % 3 == 0) && (k <= 9))
                check_val($sformatf("bu_raddr%0d", k / 3), ram_addr, 8'(k / 3));
        end
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_obs("bu_out");

        // Fill to 256 in RAM with byte 0 parked in tx_data, then overflow.
        pulse_reset();
        obs_q.delete();
        step(1'b1, 8'h00, 1'b0);
        idle(3, 1'b0);
        check_val("fi_txv0", tx_valid, 1'b1);
        check_val("fi_txd0", tx_data, 8'h00);
        check_val("fi_count0", count, 9'd0);
        for (int i = 1; i <= 256; i++) step(1'b1, 8'(i), 1'b0);
        check_val("fi_last_count", count, 9'd255);
        check_val("fi_last_full", full, 1'b0);
        check_val("fi_last_addr", ram_addr, 8'h00);
        check_val("fi_last_we", ram_we, 1'b1);
        step(1'b1, 8'h01, 1'b0);
        check_val("fi_full", full, 1'b1);
        check_val("fi_count", count, 9'd256);
        check_val("fi_ovf_pre", overflow, 1'b0);
        check_val("fi_drop_we", ram_we, 1'b0);
        check_val("fi_hold_txd", tx_data, 8'h00);
        step(1'b0, 8'h00, 1'b0);
        check_val("fi_ovf", overflow, 1'b1);
        check_val("fi_count_after_drop", count, 9'd256);
        idle(780, 1'b1);
        check_val("fi_empty", empty, 1'b1);
        check_val("fi_count_end", count, 9'd0);
        check_val("fi_ovf_sticky", overflow, 1'b1);
        check_val("fi_txv_end", tx_valid, 1'b0);
        check_val("fi_rdptr", ram_addr, 8'h01);
        exp_q.delete();
        exp_q.push_back(8'h00);
        for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
        check_obs("fi_out");
        obs_q.delete();
        step(1'b1, 8'h77, 1'b1);
        check_val("fi_wrptr_we", ram_we, 1'b1);
        check_val("fi_wrptr", ram_addr, 8'h01);
        idle(6, 1'b1);
        exp_q = '{8'h77};
        check_obs("fi_post");

        // Backpressure: tx_data stable while stalled, no loss afterwards.
        pulse_reset();
        obs_q.delete();
        step(1'b1, 8'h10, 1'b0);
        idle(3, 1'b0);
        check_val("bp_txv", tx_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(i < 5, 8'(8'h20 + i), 1'b0);
            check_val("bp_txd_stall", tx_data, 8'h10);
            check_val("bp_txv_stall", tx_valid, 1'b1);
        end
        check_val("bp_count", count, 9'd5);
        idle(20, 1'b1);
        exp_q = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        check_obs("bp_out");

        // Reset in the middle of draining.
        pulse_reset();
        obs_q.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i), 1'b0);
        idle(3, 1'b0);
        check_val("md_count_hold", count, 9'd3);
        check_val("md_txv_hold", tx_valid, 1'b1);
        check_val("md_txd_hold", tx_data, 8'h31);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("md_txv_rst", tx_valid, 1'b0);
        check_val("md_count_rst", count, 9'd0);
        check_val("md_empty_rst", empty, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        check_val("md_we", ram_we, 1'b1);
        check_val("md_addr", ram_addr, 8'h00);
        idle(6, 1'b1);
        exp_q = '{8'h5A};
        check_obs("md_out");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
